conv_ctrl_csr: RTL and testbench
================================

CONV_CTRL_CSR -- requirements
Module: conv_ctrl_csr

Parameters
REQ-001 SHALL have parameter ADDR_W, default 5, byte-address width of the register space.
REQ-002 SHALL have parameter DATA_W, default 32, register and bus data width; only 32 is supported.

Interface
REQ-003 i_clk  in  1  clock; all logic on rising edge.
REQ-004 i_reset_n  in  1  synchronous, active-low reset.
REQ-005 s_awvalid/s_awready  in/out  1/1  AXI4-Lite write-address handshake; s_awaddr  in  ADDR_W.
REQ-006 s_wvalid/s_wready  in/out  1/1  write-data handshake; s_wdata  in  32; s_wstrb  in  4.
REQ-007 s_bvalid/s_bready  out/in  1/1  write response; s_bresp  out  2.
REQ-008 s_arvalid/s_arready  in/out  1/1  read-address handshake; s_araddr  in  ADDR_W.
REQ-009 s_rvalid/s_rready  out/in  1/1  read data; s_rdata  out  32; s_rresp  out  2.
REQ-010 o_en, o_flush, o_irq_en  out  1 each  control bits to the control FSM.
REQ-011 o_irq_reg  out  1  pending-IRQ bit to the control FSM; o_irq  out  1  interrupt line, equal to o_irq_reg AND o_irq_en.
REQ-012 o_param_valid  out  1  registered parameter-check result.
REQ-013 i_validate_param, i_clear_en, i_set_irq, i_idle  in  1 each  strobes and status from the control FSM.
REQ-014 o_img_w, o_img_h, o_ch_in, o_ch_out  out  16 each; o_src_addr, o_dst_addr, o_krn_addr  out  32 each.

Function
REQ-015 Register map (byte offsets):
- 0x00 CTRL: [0] EN, [1] FLUSH, [2] IRQEN.
- 0x04 STATUS: [0] IRQ (W1C), [1] IDLE (RO), [2] PERR (W1C).
- 0x08 DIM: [15:0] W, [31:16] H.
- 0x0C CH: [15:0] CIN, [31:16] COUT.
- 0x10 SRC; 0x14 DST; 0x18 KRN.
REQ-016 The AW and W channels SHALL be accepted independently, in either order or together, one transaction at a time; s_awready/s_wready deassert once that channel is captured.
REQ-017 The register write and s_bvalid SHALL occur in the cycle after both channels are captured; s_bvalid holds until s_bready.
REQ-018 No new AW or W SHALL be accepted while s_bvalid is high.
REQ-019 s_wstrb SHALL byte-mask writes to RW and W1C bits.
REQ-020 Unmapped offsets (0x1C and above) and unaligned addresses SHALL return SLVERR (2'b10) with no state change; all others return OKAY.
REQ-021 Read: s_arready SHALL be high when no read is pending; s_rvalid and s_rdata register one cycle after the AR handshake and hold until s_rready.
REQ-022 Read data for an unmapped offset SHALL be 0 with SLVERR; unused bits read 0.
REQ-023 Writes to DIM, CH, SRC, DST and KRN while i_idle=0 SHALL be dropped and answered with SLVERR.
REQ-024 i_clear_en SHALL clear EN and FLUSH next cycle, taking priority over a simultaneous CTRL write to those bits; IRQEN still takes the written value.
REQ-025 i_set_irq SHALL set IRQ; a simultaneous W1C of IRQ loses (bit stays 1).
REQ-026 On i_validate_param, o_param_valid SHALL register next cycle as all of:
- W>=3, H>=3, CIN!=0, COUT!=0;
- SRC, DST and KRN 4-byte aligned.
REQ-027 When that registered evaluation fails, PERR SHALL set in the same cycle; set-over-W1C priority applies as for IRQ.
REQ-028 o_param_valid SHALL hold its value until the next i_validate_param.

Reset
REQ-029 Under reset all registers, o_param_valid, s_bvalid and s_rvalid SHALL be 0.
REQ-030 Under reset s_awready, s_wready and s_arready SHALL be 1.
REQ-031 Reset mid-transaction SHALL abandon it with no response issued.

Verification
REQ-032 AW in cycle 0, W in cycle 3, to 0x08 with 0x0010_0020 -> bvalid in cycle 4, OKAY; DIM reads back 0x0010_0020; o_img_w=32, o_img_h=16.
REQ-033 Write CTRL=0x5 with i_clear_en in the same cycle -> o_en=0, o_irq_en=1, o_flush=0.
REQ-034 i_set_irq with IRQEN=1, then W1C 0x1 to STATUS -> o_irq=1, then 0; repeat with i_set_irq and the W1C coincident -> o_irq stays 1.
REQ-035 DIM=0x0002_0010, CH=1/1, i_validate_param -> o_param_valid=0 and PERR=1 next cycle; DIM=0x0003_0010 -> o_param_valid=1.
REQ-036 Write SRC while i_idle=0 -> SLVERR, SRC unchanged; read 0x1C -> rdata 0, SLVERR.
REQ-037 i_reset_n low while W is captured and AW is pending -> no bvalid, all registers 0, all readies 1.

Source files
------------

// File: rtl/conv_ctrl_csr_if.sv
`timescale 1ns/1ps
`default_nettype none
// +----------------------------------------------------------------------+
// | conv_ctrl_csr_if : AXI4-Lite register-bus bundle for conv_ctrl_csr    |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
interface conv_ctrl_csr_if #(
    parameter int ADDR_W = 5,
    parameter int DATA_W = 32
);
    logic              s_awvalid;
    logic              s_awready;
    logic [ADDR_W-1:0] s_awaddr;
    logic              s_wvalid;
    logic              s_wready;
    logic [DATA_W-1:0] s_wdata;
    logic [3:0]        s_wstrb;
    logic              s_bvalid;
    logic              s_bready;
    logic [1:0]        s_bresp;
    logic              s_arvalid;
    logic              s_arready;
    logic [ADDR_W-1:0] s_araddr;
    logic              s_rvalid;
    logic              s_rready;
    logic [DATA_W-1:0] s_rdata;
    logic [1:0]        s_rresp;

    modport master (
        output s_awvalid, s_awaddr, s_wvalid, s_wdata, s_wstrb, s_bready,
               s_arvalid, s_araddr, s_rready,
        input  s_awready, s_wready, s_bvalid, s_bresp, s_arready,
               s_rvalid, s_rdata, s_rresp
    );

    modport slave (
        input  s_awvalid, s_awaddr, s_wvalid, s_wdata, s_wstrb, s_bready,
               s_arvalid, s_araddr, s_rready,
        output s_awready, s_wready, s_bvalid, s_bresp, s_arready,
               s_rvalid, s_rdata, s_rresp
    );
endinterface
`default_nettype wire

// File: rtl/conv_ctrl_csr.sv
`timescale 1ns/1ps
`default_nettype none
// +----------------------------------------------------------------------+
// | conv_ctrl_csr : AXI4-Lite CSR block for the convolution controller    |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
module conv_ctrl_csr #(
    parameter int ADDR_W = 5,
    parameter int DATA_W = 32
) (
    input  wire         i_clk,
    input  wire         i_reset_n,
    conv_ctrl_csr_if.slave s,
    output logic        o_en,
    output logic        o_flush,
    output logic        o_irq_en,
    output logic        o_irq_reg,
    output logic        o_irq,
    output logic        o_param_valid,
    input  wire         i_validate_param,
    input  wire         i_clear_en,
    input  wire         i_set_irq,
    input  wire         i_idle,
    output logic [15:0] o_img_w,
    output logic [15:0] o_img_h,
    output logic [15:0] o_ch_in,
    output logic [15:0] o_ch_out,
    output logic [31:0] o_src_addr,
    output logic [31:0] o_dst_addr,
    output logic [31:0] o_krn_addr
);
    localparam logic [1:0] c_RESP_OKAY   = 2'b00;
    localparam logic [1:0] c_RESP_SLVERR = 2'b10;

    logic              aw_got_q, w_got_q, bvalid_q, rvalid_q;
    logic [ADDR_W-1:0] aw_addr_q;
    logic [DATA_W-1:0] wdata_q, rdata_q;
    logic [3:0]        wstrb_q;
    logic [1:0]        bresp_q, rresp_q;

    logic [2:0]        ctrl_q, ctrl_d;
    logic              irq_q, irq_d, perr_q, perr_d, pv_q, pv_d;
    logic [DATA_W-1:0] dim_q, dim_d, ch_q, ch_d, src_q, src_d, dst_q, dst_d, krn_q, krn_d;

    logic              w_aw_hs, w_w_hs, w_wr_go, w_wr_ok, w_param_ok;
    logic [ADDR_W-1:0] w_wr_addr;
    logic [DATA_W-1:0] w_wr_data, w_wr_mask, w_rd_data;
    logic [3:0]        w_wr_strb;
    logic [6:0]        w_wr_sel;
    logic [1:0]        w_rd_resp;

    function automatic logic [DATA_W-1:0] f_merge(input logic [DATA_W-1:0] old_v,
                                                  input logic [DATA_W-1:0] new_v,
                                                  input logic [DATA_W-1:0] mask);
        return (old_v & ~mask) | (new_v & mask);
    endfunction

    assign s.s_awready = !aw_got_q && !bvalid_q;
    assign s.s_wready  = !w_got_q && !bvalid_q;
    assign s.s_bvalid  = bvalid_q;
    assign s.s_bresp   = bresp_q;
    assign s.s_arready = !rvalid_q;
    assign s.s_rvalid  = rvalid_q;
    assign s.s_rdata   = rdata_q;
    assign s.s_rresp   = rresp_q;

    assign w_aw_hs = s.s_awvalid && s.s_awready;
    assign w_w_hs  = s.s_wvalid && s.s_wready;
    // Commit on the edge that completes the pair, using whichever half is still on the bus.
    assign w_wr_go   = (aw_got_q || w_aw_hs) && (w_got_q || w_w_hs);
    assign w_wr_addr = aw_got_q ? aw_addr_q : s.s_awaddr;
    assign w_wr_data = w_got_q ? wdata_q : s.s_wdata;
    assign w_wr_strb = w_got_q ? wstrb_q : s.s_wstrb;
    assign w_wr_mask = {{8{w_wr_strb[3]}}, {8{w_wr_strb[2]}}, {8{w_wr_strb[1]}}, {8{w_wr_strb[0]}}};

    always_comb begin
        w_wr_sel = '0;
        if (w_wr_addr[1:0] == 2'b00) begin
            case (w_wr_addr)
                ADDR_W'('h00): w_wr_sel[0] = 1'b1;
                ADDR_W'('h04): w_wr_sel[1] = 1'b1;
                ADDR_W'('h08): w_wr_sel[2] = 1'b1;
                ADDR_W'('h0C): w_wr_sel[3] = 1'b1;
                ADDR_W'('h10): w_wr_sel[4] = 1'b1;
                ADDR_W'('h14): w_wr_sel[5] = 1'b1;
                ADDR_W'('h18): w_wr_sel[6] = 1'b1;
                default:       w_wr_sel    = '0;
            endcase
        end
        // Geometry and address registers are frozen while the engine runs.
        w_wr_ok = (|w_wr_sel) && (!(|w_wr_sel[6:2]) || i_idle);
    end

    assign w_param_ok = (dim_q[15:0] >= 16'd3) && (dim_q[31:16] >= 16'd3) &&
                        (ch_q[15:0] != 16'd0) && (ch_q[31:16] != 16'd0) &&
                        (src_q[1:0] == 2'b00) && (dst_q[1:0] == 2'b00) && (krn_q[1:0] == 2'b00);

    always_comb begin
        ctrl_d = ctrl_q;
        irq_d  = irq_q;
        perr_d = perr_q;
        pv_d   = pv_q;
        dim_d  = dim_q;
        ch_d   = ch_q;
        src_d  = src_q;
        dst_d  = dst_q;
        krn_d  = krn_q;
        if (w_wr_go && w_wr_ok) begin
            if (w_wr_sel[0]) ctrl_d = (ctrl_q & ~w_wr_mask[2:0]) | (w_wr_data[2:0] & w_wr_mask[2:0]);
            if (w_wr_sel[1] && w_wr_strb[0]) begin
                if (w_wr_data[0]) irq_d  = 1'b0;
                if (w_wr_data[2]) perr_d = 1'b0;
            end
            if (w_wr_sel[2]) dim_d = f_merge(dim_q, w_wr_data, w_wr_mask);
            if (w_wr_sel[3]) ch_d  = f_merge(ch_q,  w_wr_data, w_wr_mask);
            if (w_wr_sel[4]) src_d = f_merge(src_q, w_wr_data, w_wr_mask);
            if (w_wr_sel[5]) dst_d = f_merge(dst_q, w_wr_data, w_wr_mask);
            if (w_wr_sel[6]) krn_d = f_merge(krn_q, w_wr_data, w_wr_mask);
        end
        // Hardware events override software on the same cycle.
        if (i_clear_en) ctrl_d[1:0] = 2'b00;
        if (i_set_irq)  irq_d = 1'b1;
        if (i_validate_param) begin
            pv_d = w_param_ok;
            if (!w_param_ok) perr_d = 1'b1;
        end
    end

    always_comb begin
        w_rd_data = '0;
        w_rd_resp = c_RESP_SLVERR;
        if (s.s_araddr[1:0] == 2'b00) begin
            w_rd_resp = c_RESP_OKAY;
            case (s.s_araddr)
                ADDR_W'('h00): w_rd_data = DATA_W'(ctrl_q);
                ADDR_W'('h04): w_rd_data = DATA_W'({perr_q, i_idle, irq_q});
                ADDR_W'('h08): w_rd_data = dim_q;
                ADDR_W'('h0C): w_rd_data = ch_q;
                ADDR_W'('h10): w_rd_data = src_q;
                ADDR_W'('h14): w_rd_data = dst_q;
                ADDR_W'('h18): w_rd_data = krn_q;
                default:       w_rd_resp = c_RESP_SLVERR;
            endcase
        end
    end

    always_ff @(posedge i_clk) begin
        if (!i_reset_n) begin
            aw_got_q  <= 1'b0;
            w_got_q   <= 1'b0;
            aw_addr_q <= '0;
            wdata_q   <= '0;
            wstrb_q   <= '0;
            bvalid_q  <= 1'b0;
            bresp_q   <= c_RESP_OKAY;
            rvalid_q  <= 1'b0;
            rdata_q   <= '0;
            rresp_q   <= c_RESP_OKAY;
            ctrl_q    <= '0;
            irq_q     <= 1'b0;
            perr_q    <= 1'b0;
            pv_q      <= 1'b0;
            dim_q     <= '0;
            ch_q      <= '0;
            src_q     <= '0;
            dst_q     <= '0;
            krn_q     <= '0;
        end else begin
            if (bvalid_q && s.s_bready) bvalid_q <= 1'b0;
            if (w_wr_go) begin
                aw_got_q <= 1'b0;
                w_got_q  <= 1'b0;
                bvalid_q <= 1'b1;
                bresp_q  <= w_wr_ok ? c_RESP_OKAY : c_RESP_SLVERR;
            end else begin
                if (w_aw_hs) begin
                    aw_got_q  <= 1'b1;
                    aw_addr_q <= s.s_awaddr;
                end
                if (w_w_hs) begin
                    w_got_q <= 1'b1;
                    wdata_q <= s.s_wdata;
                    wstrb_q <= s.s_wstrb;
                end
            end
            if (rvalid_q && s.s_rready) rvalid_q <= 1'b0;
            if (s.s_arvalid && !rvalid_q) begin
                rvalid_q <= 1'b1;
                rdata_q  <= w_rd_data;
                rresp_q  <= w_rd_resp;
            end
            ctrl_q <= ctrl_d;
            irq_q  <= irq_d;
            perr_q <= perr_d;
            pv_q   <= pv_d;
            dim_q  <= dim_d;
            ch_q   <= ch_d;
            src_q  <= src_d;
            dst_q  <= dst_d;
            krn_q  <= krn_d;
        end
    end

    assign o_en          = ctrl_q[0];
    assign o_flush       = ctrl_q[1];
    assign o_irq_en      = ctrl_q[2];
    assign o_irq_reg     = irq_q;
    assign o_irq         = irq_q && ctrl_q[2];
    assign o_param_valid = pv_q;
    assign o_img_w       = dim_q[15:0];
    assign o_img_h       = dim_q[31:16];
    assign o_ch_in       = ch_q[15:0];
    assign o_ch_out      = ch_q[31:16];
    assign o_src_addr    = src_q;
    assign o_dst_addr    = dst_q;
    assign o_krn_addr    = krn_q;
endmodule
`default_nettype wire

// File: tb/tb_conv_ctrl_csr.sv
`timescale 1ns/1ps
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_conv_ctrl_csr : scoreboard bench with a register-map model         |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
module tb_conv_ctrl_csr;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    conv_ctrl_csr_if #(.ADDR_W(5), .DATA_W(32)) bus ();

    logic        o_en, o_flush, o_irq_en, o_irq_reg, o_irq, o_param_valid;
    logic        validate, clear_en, set_irq, idle_i;
    logic [15:0] o_img_w, o_img_h, o_ch_in, o_ch_out;
    logic [31:0] o_src_addr, o_dst_addr, o_krn_addr;

    conv_ctrl_csr #(.ADDR_W(5), .DATA_W(32)) dut (
        .i_clk(clk), .i_reset_n(rst_n), .s(bus),
        .o_en(o_en), .o_flush(o_flush), .o_irq_en(o_irq_en), .o_irq_reg(o_irq_reg),
        .o_irq(o_irq), .o_param_valid(o_param_valid),
        .i_validate_param(validate), .i_clear_en(clear_en), .i_set_irq(set_irq), .i_idle(idle_i),
        .o_img_w(o_img_w), .o_img_h(o_img_h), .o_ch_in(o_ch_in), .o_ch_out(o_ch_out),
        .o_src_addr(o_src_addr), .o_dst_addr(o_dst_addr), .o_krn_addr(o_krn_addr)
    );

    int n_err = 0;
    int n_chk = 0;
    logic [1:0]  wq[$];
    logic [33:0] rq[$];
    bit rand_ready = 1'b0;

    // Reference model: register contents kept as plain fields.
    logic [2:0]  m_ctrl;
    bit          m_irq, m_perr, m_pv;
    logic [31:0] m_cfg[2:6];

    task automatic chk(input string name, input logic [191:0] act, input logic [191:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic void m_reset();
        m_ctrl = '0; m_irq = 0; m_perr = 0; m_pv = 0;
        for (int i = 2; i <= 6; i++) m_cfg[i] = '0;
    endfunction

    function automatic logic [1:0] m_write(input logic [4:0] a, input logic [31:0] d, input logic [3:0] st);
        logic [31:0] m;
        int idx;
        for (int i = 0; i < 4; i++) m[i*8 +: 8] = {8{st[i]}};
        idx = int'(a) / 4;
        if ((int'(a) % 4) != 0 || idx > 6) return 2'b10;
        if (idx >= 2 && !idle_i) return 2'b10;
        if (idx == 0) m_ctrl = (m_ctrl & ~m[2:0]) | (d[2:0] & m[2:0]);
        else if (idx == 1) begin
            if (st[0] && d[0]) m_irq = 0;
            if (st[0] && d[2]) m_perr = 0;
        end else m_cfg[idx] = (m_cfg[idx] & ~m) | (d & m);
        if (clear_en) m_ctrl[1:0] = 2'b00;
        if (set_irq) m_irq = 1;
        return 2'b00;
    endfunction

    function automatic logic [33:0] m_read(input logic [4:0] a);
        int idx;
        idx = int'(a) / 4;
        if ((int'(a) % 4) != 0 || idx > 6) return {32'h0, 2'b10};
        if (idx == 0) return {29'h0, m_ctrl, 2'b00};
        if (idx == 1) return {29'h0, m_perr, idle_i, m_irq, 2'b00};
        return {m_cfg[idx], 2'b00};
    endfunction

    function automatic bit m_param_ok();
        return m_cfg[2][15:0] >= 3 && m_cfg[2][31:16] >= 3 && m_cfg[3][15:0] != 0 &&
               m_cfg[3][31:16] != 0 && m_cfg[4][1:0] == 0 && m_cfg[5][1:0] == 0 && m_cfg[6][1:0] == 0;
    endfunction

    // Response monitor: pops the scoreboard whenever a response handshake completes.
    initial begin
        logic [1:0]  eb;
        logic [33:0] er;
        forever begin
            @(negedge clk);
            if (rst_n && bus.s_bvalid && bus.s_bready) begin
                if (wq.size() == 0) begin
                    n_chk++; n_err++;
                    $display("FAIL bresp_unexpected: got bvalid resp %b, none outstanding", bus.s_bresp);
                end else begin
                    eb = wq.pop_front();
                    chk("bresp", 192'(bus.s_bresp), 192'(eb));
                end
            end
            if (rst_n && bus.s_rvalid && bus.s_rready) begin
                if (rq.size() == 0) begin
                    n_chk++; n_err++;
                    $display("FAIL rresp_unexpected: got rdata %h, none outstanding", bus.s_rdata);
                end else begin
                    er = rq.pop_front();
                    chk("rdata_rresp", 192'({bus.s_rdata, bus.s_rresp}), 192'(er));
                end
            end
        end
    end

    initial begin
        forever begin
            @(posedge clk); #1;
            bus.s_bready = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
            bus.s_rready = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // All tasks are entered and leave just after a rising edge.
    task automatic cyc(input int n);
        repeat (n) begin @(posedge clk); #1; end
    endtask

    task automatic drive(input bit do_aw, input bit do_w, input logic [4:0] a,
                         input logic [31:0] d, input logic [3:0] st);
        bit aw_p = do_aw, w_p = do_w, acc_aw, acc_w;
        int t = 0;
        bus.s_awvalid = aw_p; bus.s_awaddr = a;
        bus.s_wvalid  = w_p;  bus.s_wdata = d; bus.s_wstrb = st;
        while ((aw_p || w_p) && t < 100) begin
            @(negedge clk);
            acc_aw = aw_p && bus.s_awready;
            acc_w  = w_p && bus.s_wready;
            @(posedge clk); #1;
            if (acc_aw) begin aw_p = 0; bus.s_awvalid = 0; end
            if (acc_w)  begin w_p = 0;  bus.s_wvalid = 0;  end
            t++;
        end
        if (aw_p || w_p) begin
            n_chk++; n_err++;
            $display("FAIL write_handshake_timeout: aw pending %0b w pending %0b", aw_p, w_p);
            bus.s_awvalid = 0; bus.s_wvalid = 0;
        end
    endtask

    task automatic axi_wr(input logic [4:0] a, input logic [31:0] d, input logic [3:0] st, input int mode, input int gap);
        wq.push_back(m_write(a, d, st));
        case (mode)
            0: drive(1, 1, a, d, st);
            1: begin drive(1, 0, a, d, st); cyc(gap); drive(0, 1, a, d, st); end
            default: begin drive(0, 1, a, d, st); cyc(gap); drive(1, 0, a, d, st); end
        endcase
    endtask

    task automatic axi_rd(input logic [4:0] a);
        int t = 0;
        bit acc = 0;
        rq.push_back(m_read(a));
        bus.s_arvalid = 1; bus.s_araddr = a;
        while (!acc && t < 100) begin
            @(negedge clk);
            acc = bus.s_arready;
            @(posedge clk); #1;
            t++;
        end
        bus.s_arvalid = 0;
        if (!acc) begin
            n_chk++; n_err++;
            $display("FAIL read_handshake_timeout: arready never seen");
        end
    endtask

    task automatic pulse_validate();
        validate = 1; cyc(1); validate = 0;
        m_pv = m_param_ok();
        if (!m_pv) m_perr = 1;
    endtask

    task automatic check_outputs(input string name);
        @(negedge clk);
        chk(name,
            192'({o_en, o_flush, o_irq_en, o_irq_reg, o_irq, o_param_valid, o_img_w, o_img_h,
                  o_ch_in, o_ch_out, o_src_addr, o_dst_addr, o_krn_addr}),
            192'({m_ctrl[0], m_ctrl[1], m_ctrl[2], m_irq, m_irq & m_ctrl[2], m_pv,
                  m_cfg[2][15:0], m_cfg[2][31:16], m_cfg[3][15:0], m_cfg[3][31:16],
                  m_cfg[4], m_cfg[5], m_cfg[6]}));
        @(posedge clk); #1;
    endtask

    task automatic drain();
        int t = 0;
        while ((wq.size() != 0 || rq.size() != 0) && t < 200) begin cyc(1); t++; end
        if (wq.size() != 0 || rq.size() != 0) begin
            n_chk++; n_err++;
            $display("FAIL drain_timeout: got %0d writes %0d reads outstanding, expected 0", wq.size(), rq.size());
            wq.delete(); rq.delete();
        end
    endtask

    task automatic check_reset_pins(input string name);
        @(negedge clk);
        chk(name, 192'({bus.s_awready, bus.s_wready, bus.s_arready, bus.s_bvalid, bus.s_rvalid}),
            192'(5'b11100));
    endtask

    initial begin
        logic [4:0]  a;
        logic [31:0] d;
        logic [3:0]  st;
        int op;
        bus.s_awvalid = 0; bus.s_awaddr = '0; bus.s_wvalid = 0; bus.s_wdata = '0; bus.s_wstrb = '0;
        bus.s_arvalid = 0; bus.s_araddr = '0; bus.s_bready = 1; bus.s_rready = 1;
        validate = 0; clear_en = 0; set_irq = 0; idle_i = 1;
        m_reset();
        repeat (3) @(posedge clk);
        check_reset_pins("reset_handshake");
        @(posedge clk); #1;
        rst_n = 1;
        check_outputs("reset_outputs");

        // AW first, W three cycles later: response appears the cycle after W.
        wq.push_back(m_write(5'h08, 32'h0010_0020, 4'hF));
        drive(1, 0, 5'h08, 32'h0010_0020, 4'hF);
        @(negedge clk);
        chk("bvalid_before_w", 192'(bus.s_bvalid), 192'(0));
        @(posedge clk); #1;
        cyc(1);
        drive(0, 1, 5'h08, 32'h0010_0020, 4'hF);
        @(negedge clk);
        chk("bvalid_after_w", 192'(bus.s_bvalid), 192'(1));
        @(posedge clk); #1;
        axi_rd(5'h08);
        check_outputs("dim_outputs");

        clear_en = 1;
        axi_wr(5'h00, 32'h5, 4'hF, 0, 0);
        clear_en = 0;
        check_outputs("ctrl_clear_en");

        set_irq = 1; cyc(1); set_irq = 0; m_irq = 1;
        check_outputs("irq_set");
        axi_wr(5'h04, 32'h1, 4'hF, 1, 1);
        check_outputs("irq_w1c");
        set_irq = 1;
        axi_wr(5'h04, 32'h1, 4'hF, 0, 0);
        set_irq = 0;
        check_outputs("irq_set_beats_w1c");

        axi_wr(5'h08, 32'h0002_0010, 4'hF, 2, 1);
        axi_wr(5'h0C, 32'h0001_0001, 4'hF, 0, 0);
        pulse_validate();
        check_outputs("param_bad_h");
        axi_rd(5'h04);
        axi_wr(5'h08, 32'h0003_0010, 4'hF, 0, 0);
        pulse_validate();
        check_outputs("param_good");

        idle_i = 0;
        axi_wr(5'h10, 32'hDEAD_BEEF, 4'hF, 0, 0);
        axi_rd(5'h10);
        idle_i = 1;
        axi_rd(5'h1C);
        axi_rd(5'h06);
        drain();

        // Randomised traffic with stalled response channels.
        rand_ready = 1;
        for (int i = 0; i < 300; i++) begin
            idle_i = ($urandom_range(0, 7) != 0);
            op = $urandom_range(0, 9);
            a = ($urandom_range(0, 9) < 7) ? 5'({3'($urandom_range(0, 7)), 2'b00}) : 5'($urandom_range(0, 31));
            d = $urandom_range(0, 1) ? $urandom : {16'($urandom_range(0, 4)), 16'($urandom_range(0, 4))};
            st = $urandom_range(0, 1) ? 4'hF : 4'($urandom_range(0, 15));
            if (op <= 4) axi_wr(a, d, st, $urandom_range(0, 2), $urandom_range(0, 3));
            else if (op <= 7) axi_rd(a);
            else if (op == 8) begin pulse_validate(); check_outputs("rand_validate"); end
            else check_outputs("rand_outputs");
        end
        rand_ready = 0;
        idle_i = 1;
        drain();
        check_outputs("rand_final");

        // Reset while W is captured and AW is still pending.
        drive(0, 1, 5'h14, 32'h1234_5678, 4'hF);
        bus.s_awvalid = 1; bus.s_awaddr = 5'h14;
        rst_n = 0;
        cyc(1);
        check_reset_pins("midtxn_reset_pins");
        @(posedge clk); #1;
        bus.s_awvalid = 0;
        rst_n = 1;
        m_reset();
        cyc(5);
        check_outputs("midtxn_reset_regs");
        for (int i = 0; i < 7; i++) axi_rd(5'(i * 4));
        drain();

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end
endmodule
`default_nettype wire
